// File: rtl/lfsr_stimulus_bank.sv
// rtl/lfsr_stimulus_bank.sv - multi-channel Galois LFSR stimulus source with run modes
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   reset       asynchronous active-high reset, loads seeds derived from SEED_BASE
//   mode        00 FREE, 01 STEP, 10 HOLD, 11 BURST
//   step        advance request (STEP mode) / burst start (BURST mode)
//   burst_len   number of advances performed by one burst
//   reseed      load channel seeds derived from seed_in
//   seed_in     runtime base seed
//   rnd_out     channel c at bits [c*WIDTH +: WIDTH]
//   rnd_valid   one cycle high after each advance or reseed
//   burst_busy  high while a burst is running
//   adv_count   saturating count of advance cycles since reset

module lfsr_stimulus_bank #(
    parameter int unsigned      NUM_CH    = 4,
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] POLY      = 32'hB4BCD35C,
    parameter int unsigned      SEED_BASE = 3,
    parameter int unsigned      BURST_W   = 8,
    parameter int unsigned      CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                mode,
    input  logic                      step,
    input  logic [BURST_W-1:0]        burst_len,
    input  logic                      reseed,
    input  logic [WIDTH-1:0]          seed_in,
    output logic [NUM_CH*WIDTH-1:0]   rnd_out,
    output logic                      rnd_valid,
    output logic                      burst_busy,
    output logic [CNT_W-1:0]          adv_count
);

    localparam logic [1:0] MODE_FREE  = 2'b00;
    localparam logic [1:0] MODE_STEP  = 2'b01;
    localparam logic [1:0] MODE_HOLD  = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    localparam logic [WIDTH-1:0]   RESET_BASE = WIDTH'(SEED_BASE);
    localparam logic [WIDTH-1:0]   ONE_W      = WIDTH'(1);
    localparam logic [BURST_W-1:0] ONE_B      = BURST_W'(1);
    localparam logic [CNT_W-1:0]   ONE_C      = CNT_W'(1);

    typedef enum logic {IDLE, RUN} burst_state_t;

    burst_state_t       burst_state;
    logic [BURST_W-1:0] burst_rem;
    logic [WIDTH-1:0]   lfsr [NUM_CH];
    logic               advance;

    // Channel seeds are spaced by 2 so channels never share a sequence phase
    // for the same base; zero is the Galois lock-up state and is forced to 1.
    function automatic logic [WIDTH-1:0] seed_of(input logic [WIDTH-1:0] base,
                                                 input int unsigned      ch);
        logic [WIDTH-1:0] v;
        v = base + WIDTH'(2 * ch);
        if (v == '0) begin
            v = ONE_W;
        end
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        return (s >> 1) ^ (s[0] ? POLY : '0);
    endfunction

    // Reseed wins over any advance requested in the same cycle.
    always_comb begin
        advance = 1'b0;
        case (mode)
            MODE_FREE:  advance = 1'b1;
            MODE_STEP:  advance = step;
            MODE_HOLD:  advance = 1'b0;
            MODE_BURST: advance = (burst_state == RUN);
            default:    advance = 1'b0;
        endcase
        if (reseed) begin
            advance = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                lfsr[c] <= seed_of(RESET_BASE, c);
            end
            rnd_valid   <= 1'b0;
            adv_count   <= '0;
            burst_state <= IDLE;
            burst_rem   <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (reseed) begin
                    lfsr[c] <= seed_of(seed_in, c);
                end else if (advance) begin
                    lfsr[c] <= lfsr_next(lfsr[c]);
                end
            end

            rnd_valid <= advance | reseed;

            if (advance && adv_count != '1) begin
                adv_count <= adv_count + ONE_C;
            end

            case (burst_state)
                IDLE: begin
                    // The start cycle only arms the burst; advancing begins next cycle.
                    if (!reseed && mode == MODE_BURST && step && burst_len != '0) begin
                        burst_state <= RUN;
                        burst_rem   <= burst_len;
                    end
                end
                RUN: begin
                    if (reseed || mode != MODE_BURST) begin
                        burst_state <= IDLE;
                        burst_rem   <= '0;
                    end else if (burst_rem == ONE_B) begin
                        burst_state <= IDLE;
                        burst_rem   <= '0;
                    end else begin
                        burst_rem <= burst_rem - ONE_B;
                    end
                end
                default: begin
                    burst_state <= IDLE;
                    burst_rem   <= '0;
                end
            endcase
        end
    end

    assign burst_busy = (burst_state == RUN);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign rnd_out[g*WIDTH +: WIDTH] = lfsr[g];
    end

endmodule

// File: tb/tb_lfsr_stimulus_bank.sv
// tb/tb_lfsr_stimulus_bank.sv - self-checking bench for lfsr_stimulus_bank

module tb_lfsr_stimulus_bank;

    localparam int NUM_CH = 2;
    localparam int WIDTH  = 8;
    localparam int CNT_W  = 4;

    logic        clk;
    logic        reset;
    logic [1:0]  mode;
    logic        step;
    logic [7:0]  burst_len;
    logic        reseed;
    logic [7:0]  seed_in;
    logic [15:0] rnd_out;
    logic        rnd_valid;
    logic        burst_busy;
    logic [3:0]  adv_count;

    int total = 0;
    int bad   = 0;

    lfsr_stimulus_bank #(
        .NUM_CH(NUM_CH), .WIDTH(WIDTH), .POLY(8'hB8),
        .SEED_BASE(3), .BURST_W(8), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .step(step),
        .burst_len(burst_len), .reseed(reseed), .seed_in(seed_in),
        .rnd_out(rnd_out), .rnd_valid(rnd_valid),
        .burst_busy(burst_busy), .adv_count(adv_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per-channel value, pending burst advances, saturating count.
    logic [7:0] m_s [2];
    logic       m_valid;
    int         m_left;
    int         m_cnt;

    function automatic logic [7:0] m_seed(input logic [7:0] base, input int c);
        logic [7:0] v;
        v = base + 8'(2 * c);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

    function automatic logic [7:0] m_next(input logic [7:0] v);
        return (v % 2 == 1) ? ((v / 2) ^ 8'hB8) : (v / 2);
    endfunction

    function automatic bit m_adv();
        case (mode)
            2'd0:    return 1'b1;
            2'd1:    return step;
            2'd2:    return 1'b0;
            default: return m_left > 0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) m_s[i] <= m_seed(8'd3, i);
            m_valid <= 1'b0;
            m_left  <= 0;
            m_cnt   <= 0;
        end else if (reseed) begin
            for (int i = 0; i < 2; i++) m_s[i] <= m_seed(seed_in, i);
            m_valid <= 1'b1;
            m_left  <= 0;
        end else begin
            for (int i = 0; i < 2; i++) if (m_adv()) m_s[i] <= m_next(m_s[i]);
            m_valid <= m_adv();
            if (m_adv() && m_cnt < 15) m_cnt <= m_cnt + 1;
            if (m_left > 0) m_left <= (mode != 2'd3) ? 0 : m_left - 1;
            else if (mode == 2'd3 && step && burst_len != 0) m_left <= int'(burst_len);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    bit started = 0;

    always @(negedge clk) begin
        if (started) begin
            chk("model_rnd_out", 32'(rnd_out), 32'({m_s[1], m_s[0]}));
            chk("model_rnd_valid", 32'(rnd_valid), 32'(m_valid));
            chk("model_burst_busy", 32'(burst_busy), 32'(m_left > 0));
            chk("model_adv_count", 32'(adv_count), 32'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] snap;
    int          busy_seen;

    initial begin
        reset = 1'b0; mode = 2'd2; step = 1'b0; burst_len = 8'd0;
        reseed = 1'b0; seed_in = 8'd0;
        #1 reset = 1'b1;
        started = 1;
        #12;
        @(negedge clk) reset = 1'b0;

        // HOLD after reset: seeds stay put
        repeat (5) tick();
        chk("hold_rnd_out", 32'(rnd_out), 32'h0503);
        chk("hold_valid", 32'(rnd_valid), 32'd0);
        chk("hold_count", 32'(adv_count), 32'd0);

        // FREE for two cycles
        mode = 2'd0;
        tick();
        chk("free1_rnd_out", 32'(rnd_out), 32'hBAB9);
        chk("free1_valid", 32'(rnd_valid), 32'd1);
        reseed = 1'b1; seed_in = 8'hFE;
        chk("free2_rnd_out", 32'(rnd_out), 32'hBAB9);
        tick();
        // this edge was the reseed; check the FREE value first by history
        chk("reseed_rnd_out", 32'(rnd_out), 32'h01FE);
        chk("reseed_count", 32'(adv_count), 32'd1);
        chk("reseed_valid", 32'(rnd_valid), 32'd1);
        reseed = 1'b0; mode = 2'd2;
        tick();
        chk("after_reseed_valid", 32'(rnd_valid), 32'd0);

        // Second FREE advance count check via a fresh pair of FREE cycles
        reseed = 1'b1; seed_in = 8'd3;
        tick();
        reseed = 1'b0; mode = 2'd0;
        tick();
        tick();
        chk("free_two_rnd_out", 32'(rnd_out), 32'h5DE4);
        chk("free_two_count", 32'(adv_count), 32'd3);

        // reseed FE in FREE mode: adv_count unchanged
        reseed = 1'b1; seed_in = 8'hFE;
        tick();
        reseed = 1'b0; mode = 2'd2;
        chk("reseed_fe", 32'(rnd_out), 32'h01FE);
        chk("reseed_fe_count", 32'(adv_count), 32'd3);

        // BURST of 3 with an ignored mid-burst step
        mode = 2'd3; burst_len = 8'd3; step = 1'b1;
        tick();
        busy_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (burst_busy) busy_seen++;
            step = (i == 1);
            tick();
        end
        step = 1'b0;
        chk("burst_busy_cycles", 32'(busy_seen), 32'd3);
        chk("burst_rnd_out", 32'(rnd_out), 32'h2EFB);
        chk("burst_count", 32'(adv_count), 32'd6);
        chk("burst_idle_busy", 32'(burst_busy), 32'd0);

        // burst_len = 0 start does nothing
        burst_len = 8'd0; step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        chk("len0_busy", 32'(burst_busy), 32'd0);
        chk("len0_rnd_out", 32'(rnd_out), 32'h2EFB);
        chk("len0_count", 32'(adv_count), 32'd6);

        // Async reset mid-burst, asserted between edges
        burst_len = 8'd10; step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        chk("pre_reset_busy", 32'(burst_busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rnd_out", 32'(rnd_out), 32'h0503);
        chk("async_busy", 32'(burst_busy), 32'd0);
        chk("async_count", 32'(adv_count), 32'd0);
        chk("async_valid", 32'(rnd_valid), 32'd0);
        @(negedge clk) reset = 1'b0;
        tick();

        // Mode switch to HOLD mid-burst
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        mode = 2'd2;
        snap = rnd_out;
        tick();
        chk("abort_busy", 32'(burst_busy), 32'd0);
        chk("abort_freeze", 32'(rnd_out), 32'(snap));
        tick();
        chk("abort_freeze2", 32'(rnd_out), 32'(snap));
        chk("abort_count", 32'(adv_count), 32'd2);

        // STEP pulses to saturation
        mode = 2'd1;
        for (int i = 0; i < 20; i++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            tick();
            if (i == 11) chk("step_count_14", 32'(adv_count), 32'd14);
        end
        chk("saturated", 32'(adv_count), 32'hF);

        // Randomized phase against the model
        reset = 1'b1;
        #3;
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            step      = ($urandom_range(0, 2) == 0);
            burst_len = 8'($urandom_range(0, 5));
            reseed    = ($urandom_range(0, 15) == 0);
            seed_in   = 8'($urandom);
            if ($urandom_range(0, 20) == 0) seed_in = 8'hFE;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
